// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: runs the CPU for a bounded number of cycles, then dumps
// its register file one valid/ready beat at a time. Option: RUN_MONITOR_CHECKSUM_EN.
module cpu_run_monitor #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int MAX_CYCLES = 100,
  localparam int IW        = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int CW        = $clog2(MAX_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            halt,
  output logic            cpu_run,
  output logic [IW-1:0]   rf_addr,
  input  logic [XLEN-1:0] rf_data,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [IW-1:0]   dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_last,
  output logic [CW-1:0]   cycle_count,
  output logic            done,
  output logic            timed_out,
  output logic [XLEN-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);
  localparam logic [CW-1:0] CNT_LIM  = CW'(MAX_CYCLES - 1);

  state_t          state_q;
  logic            run_q;
  logic            valid_q;
  logic            last_q;
  logic            done_q;
  logic            to_q;
  logic [IW-1:0]   idx_q;
  logic [XLEN-1:0] data_q;
  logic [CW-1:0]   cnt_q;

  // Run/dump sequencer; every output comes straight from a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            run_q   <= 1'b1;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
          end
        end
        S_RUN: begin
          // halt wins when it lands on the final budget cycle
          if (halt || cnt_q == CNT_LIM) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
            to_q    <= !halt;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FETCH: begin
          data_q  <= rf_data;
          last_q  <= (idx_q == LAST_IDX);
          valid_q <= 1'b1;
          state_q <= S_PRESENT;
        end
        S_PRESENT: begin
          if (dump_ready) begin
            valid_q <= 1'b0;
            if (last_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              last_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_run     = run_q;
  assign rf_addr     = idx_q;
  assign dump_valid  = valid_q;
  assign dump_idx    = idx_q;
  assign dump_data   = data_q;
  assign dump_last   = last_q;
  assign cycle_count = cnt_q;
  assign done        = done_q;
  assign timed_out   = to_q;

`ifdef RUN_MONITOR_CHECKSUM_EN
  logic            accept;
  logic            restart;
  logic [XLEN-1:0] cs_q;

  assign accept  = (state_q == S_PRESENT) && dump_ready;
  assign restart = (state_q == S_IDLE || state_q == S_DONE) && start;

  // Running XOR of every accepted beat, cleared when a run starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q <= '0;
    end else if (restart) begin
      cs_q <= '0;
    end else if (accept) begin
      cs_q <= cs_q ^ data_q;
    end
  end

  assign checksum = cs_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: directed runs against a cycle-level behavioural
// model, plus literal checks on run length, beat order and checksums.
module tb_cpu_run_monitor;
  localparam int NREGS = 32;
  localparam int MAXC  = 100;

`ifdef RUN_MONITOR_CHECKSUM_EN
  localparam bit CS_ON = 1'b1;
`else
  localparam bit CS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, halt;
  logic        dump_ready = 1'b0;
  logic        cpu_run, dump_valid, dump_last, done, timed_out;
  logic [4:0]  rf_addr, dump_idx;
  logic [31:0] rf_data, dump_data, checksum;
  logic [6:0]  cycle_count;
  logic [31:0] rf_mem [NREGS];

  assign rf_data = rf_mem[rf_addr];

  cpu_run_monitor dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .cpu_run(cpu_run), .rf_addr(rf_addr), .rf_data(rf_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_last(dump_last), .cycle_count(cycle_count),
    .done(done), .timed_out(timed_out), .checksum(checksum)
  );

  logic        s_start, s_halt, s_ready;
  logic        s_run, s_dv, s_dl, s_done, s_to;
  logic [1:0]  s_addr, s_di, s_cc;
  logic [15:0] s_rdata, s_dd, s_cs;
  logic [15:0] s_rf [4];

  assign s_rdata = s_rf[s_addr];

  cpu_run_monitor #(.XLEN(16), .NREGS(4), .MAX_CYCLES(3)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .halt(s_halt),
    .cpu_run(s_run), .rf_addr(s_addr), .rf_data(s_rdata),
    .dump_valid(s_dv), .dump_ready(s_ready),
    .dump_idx(s_di), .dump_data(s_dd),
    .dump_last(s_dl), .cycle_count(s_cc),
    .done(s_done), .timed_out(s_to), .checksum(s_cs)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 running, 2 gap before a beat,
  // 3 beat offered, 4 finished. m_k is the 1-based run cycle number.
  int          ph = 0;
  int          m_k = 1;
  int          m_idx = 0;
  logic [31:0] m_data = '0;
  logic [31:0] m_cs = '0;
  bit          m_done = 0, m_to = 0, m_rst = 0, m_live = 0;

  always @(posedge clk) begin
    if (reset) begin
      ph = 0; m_k = 1; m_idx = 0; m_data = '0; m_cs = '0;
      m_done = 0; m_to = 0; m_rst = 1; m_live = 1;
    end else begin
      case (ph)
        0, 4: if (start) begin
          ph = 1; m_k = 1; m_idx = 0; m_cs = '0;
          m_done = 0; m_to = 0; m_rst = 0;
        end
        1: begin
          if (halt) ph = 2;
          else if (m_k == MAXC) begin ph = 2; m_to = 1; end
          else m_k++;
        end
        2: begin m_data = rf_mem[m_idx]; ph = 3; end
        3: if (dump_ready) begin
          m_cs ^= m_data;
          if (m_idx == NREGS - 1) begin ph = 4; m_done = 1; end
          else begin m_idx++; ph = 2; end
        end
        default: ;
      endcase
    end
  end

  // Per-cycle compare of the DUT against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("cpu_run", cpu_run, ph == 1);
      chk("dump_valid", dump_valid, ph == 3);
      chk("dump_idx", dump_idx, m_idx);
      chk("rf_addr", rf_addr, m_idx);
      chk("cycle_count", cycle_count, m_k - 1);
      chk("done", done, m_done);
      chk("timed_out", timed_out, m_to);
      if (ph == 3 || m_rst) begin
        chk("dump_data", dump_data, m_data);
        chk("dump_last", dump_last, ph == 3 && m_idx == NREGS - 1);
      end
      if (ph < 2 || ph == 4)
        chk("checksum", checksum, CS_ON ? m_cs : 32'h0);
    end
  end

  // Consumer: drives dump_ready, logs run cycles and offered-and-taken beats.
  int tot_run = 0;
  int acc_idx[$];
  bit acc_last[$];
  int stall_at = -1, stall_len = 0, stall_cnt = 0, stall_seen = 0;
  bit ready_base = 1'b1;

  always @(negedge clk) begin
    if (cpu_run) tot_run++;
    if (dump_valid && int'(dump_idx) == stall_at) stall_seen++;
    if (dump_valid && int'(dump_idx) == stall_at && stall_cnt < stall_len) begin
      dump_ready = 1'b0;
      stall_cnt++;
    end else begin
      dump_ready = ready_base;
    end
    if (dump_valid && dump_ready) begin
      acc_idx.push_back(int'(dump_idx));
      acc_last.push_back(dump_last);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, done, 1'b1);
  endtask

  task automatic check_run(input string tag, input int r0, input int a0,
                           input int er, input bit eto, input int ecc);
    int nb;
    chk({tag, "_runcyc"}, tot_run - r0, er);
    chk({tag, "_to"}, timed_out, eto);
    chk({tag, "_cc"}, cycle_count, ecc);
    nb = acc_idx.size() - a0;
    chk({tag, "_beats"}, nb, NREGS);
    if (nb == NREGS) begin
      for (int i = 0; i < NREGS; i++) begin
        chk({tag, "_order"}, acc_idx[a0 + i], i);
        chk({tag, "_last"}, acc_last[a0 + i], i == NREGS - 1);
      end
    end
  endtask

  task automatic small_run(input string tag);
    int runs = 0, beats = 0, nlast = 0, lidx = -1, n = 0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk({tag, "_clr_done"}, s_done, 1'b0);
    chk({tag, "_clr_cc"}, s_cc, 0);
    while (!s_done && n < 60) begin
      if (s_run) runs++;
      if (s_dv) begin
        beats++;
        if (s_dl) begin nlast++; lidx = int'(s_di); end
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, s_done, 1'b1);
    chk({tag, "_runcyc"}, runs, 3);
    chk({tag, "_beats"}, beats, 4);
    chk({tag, "_nlast"}, nlast, 1);
    chk({tag, "_lastidx"}, lidx, 3);
    chk({tag, "_to"}, s_to, 1'b1);
    chk({tag, "_cc"}, s_cc, 2);
    chk({tag, "_cs"}, s_cs, CS_ON ? 16'h000F : 16'h0);
  endtask

  initial begin
    int r0, a0, n;
    reset = 1'b1; start = 1'b0; halt = 1'b0;
    s_start = 1'b0; s_halt = 1'b0; s_ready = 1'b1;
    for (int i = 0; i < NREGS; i++) rf_mem[i] = '0;
    for (int i = 0; i < 4; i++) s_rf[i] = 16'(1 << i);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_cpu_run", cpu_run, 1'b0);
    chk("rst_valid", dump_valid, 1'b0);
    chk("rst_idx", dump_idx, 0);
    chk("rst_data", dump_data, 0);
    chk("rst_done", done, 1'b0);
    chk("rst_cs", checksum, 0);

    // Budget exhausted, random register contents.
    for (int i = 0; i < NREGS; i++) rf_mem[i] = $urandom;
    r0 = tot_run; a0 = acc_idx.size();
    pulse_start();
    wait_done("t1_done", 400);
    check_run("t1", r0, a0, 100, 1'b1, 99);

    // Halt on the 10th run cycle.
    for (int i = 0; i < NREGS; i++) rf_mem[i] = $urandom;
    r0 = tot_run; a0 = acc_idx.size();
    pulse_start();
    repeat (9) @(negedge clk);
    halt = 1'b1;
    wait_done("t2_done", 200);
    halt = 1'b0;
    check_run("t2", r0, a0, 10, 1'b0, 9);

    // Consumer stalls beat 3 for five cycles; halt held from the start.
    stall_at = 3; stall_len = 5;
    r0 = tot_run; a0 = acc_idx.size();
    halt = 1'b1;
    pulse_start();
    wait_done("t3_done", 200);
    halt = 1'b0;
    check_run("t3", r0, a0, 1, 1'b0, 0);
    chk("t3_stall_cycles", stall_seen, 6);
    stall_at = -1;

    // Reset lands while beat 7 is offered.
    halt = 1'b1;
    pulse_start();
    n = 0;
    while (!(dump_valid && dump_idx == 5'd7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reach_beat7", dump_valid && dump_idx == 5'd7, 1'b1);
    halt = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t4_valid", dump_valid, 1'b0);
    chk("t4_cpu_run", cpu_run, 1'b0);
    chk("t4_idx", dump_idx, 0);
    chk("t4_data", dump_data, 0);
    chk("t4_last", dump_last, 1'b0);
    chk("t4_cc", cycle_count, 0);
    chk("t4_done", done, 1'b0);
    chk("t4_to", timed_out, 1'b0);
    chk("t4_cs", checksum, 0);
    r0 = tot_run; a0 = acc_idx.size();
    pulse_start();
    wait_done("t4b_done", 400);
    check_run("t4b", r0, a0, 100, 1'b1, 99);

    // Halt on the final budget cycle.
    r0 = tot_run; a0 = acc_idx.size();
    pulse_start();
    repeat (99) @(negedge clk);
    halt = 1'b1;
    wait_done("t5_done", 200);
    halt = 1'b0;
    check_run("t5", r0, a0, 100, 1'b0, 99);

    // Checksum patterns.
    for (int i = 0; i < NREGS; i++) rf_mem[i] = i;
    halt = 1'b1;
    pulse_start();
    wait_done("t6a_done", 200);
    chk("t6_cs_idx", checksum, 32'h0);
    for (int i = 0; i < NREGS; i++) rf_mem[i] = 32'(1) << i;
    pulse_start();
    wait_done("t6b_done", 200);
    halt = 1'b0;
    chk("t6_cs_pow2", checksum, CS_ON ? 32'hFFFF_FFFF : 32'h0);

    // Small configuration, then a restart from DONE.
    small_run("t7a");
    small_run("t7b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
